// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, immediate format codes and immediate assembly.
// The control decoder uses the same opcode constants, so keep additions backward compatible.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_NONE = 3'b111
  } imm_src_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } stage_state_t;

  // Every format is assembled as a 32-bit value already sign-extended to bit 31;
  // widening to XLEN is then a plain signed extension by the caller.
  function automatic logic [31:0] build_imm32(input imm_src_t src, input logic [31:0] instr);
    logic [31:0] imm;
    imm = '0;
    case (src)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for the immediate-decode stage: upstream instruction side and downstream entry side.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_src_t        out_immsrc;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_immsrc, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_immsrc, out_pc, out_illegal
  );

endinterface

// File: rtl/imm_extend.sv
// Combinational opcode classifier: picks the immediate format, builds the XLEN-wide
// sign-extended immediate and flags opcodes outside the supported RV32I/RV64I set.
module imm_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_src_t        imm_src,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm_src = IMM_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_I, OP_LOAD, OP_JALR: imm_src = IMM_I;
      OP_STORE:               imm_src = IMM_S;
      OP_BRANCH:              imm_src = IMM_B;
      OP_JAL:                 imm_src = IMM_J;
      OP_LUI, OP_AUIPC:       imm_src = IMM_U;
      OP_R:                   imm_src = IMM_NONE;
      default:                illegal = 1'b1;
    endcase
  end

  assign imm32 = build_imm32(imm_src, instr);

  // Signed cast makes U-type upper bits follow inst[31] when XLEN is 64.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: one instruction per handshake, decoded entry presented
// the following cycle, with an optional second (skid) entry so in_ready can be a flop.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  imm_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_src_t        immsrc;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{imm: '0, immsrc: IMM_NONE, pc: '0, illegal: 1'b0};

  stage_state_t    state;
  stage_state_t    state_next;
  entry_t          out_q;
  entry_t          skid_q;
  entry_t          in_entry;
  logic            ready_q;
  logic            accept;
  logic            pop;
  logic            load_out_in;
  logic            load_out_skid;
  logic            load_skid;
  logic [XLEN-1:0] dec_imm;
  imm_src_t        dec_src;
  logic            dec_illegal;

  imm_extend #(.XLEN(XLEN)) u_extend (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .imm_src (dec_src),
    .illegal (dec_illegal)
  );

  assign in_entry = '{imm: dec_imm, immsrc: dec_src, pc: bus.in_pc, illegal: dec_illegal};

  assign bus.out_valid = (state != ST_EMPTY);

  // With the skid entry, in_ready comes from a flop; reset only masks it while asserted.
  assign bus.in_ready = (SKID != 0) ? (ready_q && !reset)
                                    : (!reset && (!bus.out_valid || bus.out_ready));

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next  = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_out_in = 1'b1;
        end else if (accept && (SKID != 0)) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Flush and reset share one path: both empty the stage and restore the idle output fields.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= ST_EMPTY;
      out_q   <= RESET_ENTRY;
      skid_q  <= RESET_ENTRY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != ST_TWO);
      if (load_out_in) begin
        out_q <= in_entry;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.out_imm     = out_q.imm;
  assign bus.out_immsrc  = out_q.immsrc;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit skid instance and a 64-bit single-stage instance.
module tb_imm_decode_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus32 ();
  imm_decode_stage_if #(.XLEN(64)) bus64 ();

  imm_decode_stage #(.XLEN(32), .SKID(1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus32.slave)
  );

  imm_decode_stage #(.XLEN(64), .SKID(0)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus64.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus32.in_valid = 1'b0; bus32.in_instr = 32'h0; bus32.in_pc = 32'h0; bus32.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = 32'h0; bus64.in_pc = 64'h0; bus64.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready32: got %b want 0", bus32.in_ready); end
    checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready64: got %b want 0", bus64.in_ready); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus32.out_valid); end
    checks++; if (bus32.out_imm !== 32'h0 || bus32.out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_imm_pc: got %h/%h want 0/0", bus32.out_imm, bus32.out_pc); end
    checks++; if (bus32.out_immsrc !== 3'b111 || bus32.out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_ill: got %b/%b want 111/0", bus32.out_immsrc, bus32.out_illegal); end
    checks++; if (bus64.out_valid !== 1'b0 || bus64.out_imm !== 64'h0 || bus64.out_immsrc !== 3'b111) begin errors++; $display("[TB] FAIL reset_out64: got v=%b imm=%h src=%b want 0/0/111", bus64.out_valid, bus64.out_imm, bus64.out_immsrc); end
    reset = 1'b0;
    tick();
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready32: got %b want 1", bus32.in_ready); end
    checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready64: got %b want 1", bus64.in_ready); end
  endtask

  task automatic test_decode32();
    logic [31:0] instrs [9] = '{32'hFFC12083, 32'h00512423, 32'hFE000CE3, 32'h123450B7, 32'h0000007F,
                                32'h002081B3, 32'h008000EF, 32'hFFF00093, 32'hFFFFF097};
    logic [31:0] imms   [9] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFF8, 32'h12345000, 32'h00000000,
                                32'h00000000, 32'h00000008, 32'hFFFFFFFF, 32'hFFFFF000};
    logic [2:0]  srcs   [9] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111, 3'b111, 3'b011, 3'b000, 3'b100};
    logic        ills   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_instr = instrs[i];
      bus32.in_pc    = 32'h1000 + 32'(i * 4);
      checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dec_ready[%0d]: got %b want 1", i, bus32.in_ready); end
      tick();
      bus32.in_valid = 1'b0;
      checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec_valid[%0d]: got %b want 1", i, bus32.out_valid); end
      checks++; if (bus32.out_imm !== imms[i]) begin errors++; $display("[TB] FAIL dec_imm[%0d]: got %h want %h", i, bus32.out_imm, imms[i]); end
      checks++; if (bus32.out_immsrc !== srcs[i]) begin errors++; $display("[TB] FAIL dec_src[%0d]: got %b want %b", i, bus32.out_immsrc, srcs[i]); end
      checks++; if (bus32.out_illegal !== ills[i]) begin errors++; $display("[TB] FAIL dec_ill[%0d]: got %b want %b", i, bus32.out_illegal, ills[i]); end
      checks++; if (bus32.out_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("[TB] FAIL dec_pc[%0d]: got %h want %h", i, bus32.out_pc, 32'h1000 + 32'(i * 4)); end
    end
    tick();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dec_drain: got %b want 0", bus32.out_valid); end
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_xlen64();
    logic [31:0] instrs [3] = '{32'h800000B7, 32'hFFC12083, 32'hFE000CE3};
    logic [63:0] imms   [3] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8};
    logic [2:0]  srcs   [3] = '{3'b100, 3'b000, 3'b010};
    for (int i = 0; i < 3; i++) begin
      bus64.in_valid  = 1'b1;
      bus64.in_instr  = instrs[i];
      bus64.in_pc     = 64'h8000_0000_0000_0000 + 64'(i * 4);
      bus64.out_ready = 1'b0;
      tick();
      bus64.in_valid = 1'b0;
      checks++; if (bus64.out_valid !== 1'b1 || bus64.out_imm !== imms[i] || bus64.out_immsrc !== srcs[i]) begin errors++; $display("[TB] FAIL x64_entry[%0d]: got v=%b imm=%h src=%b want 1/%h/%b", i, bus64.out_valid, bus64.out_imm, bus64.out_immsrc, imms[i], srcs[i]); end
      checks++; if (bus64.out_pc !== 64'h8000_0000_0000_0000 + 64'(i * 4)) begin errors++; $display("[TB] FAIL x64_pc[%0d]: got %h", i, bus64.out_pc); end
      checks++; if (bus64.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL x64_ready_full[%0d]: got %b want 0", i, bus64.in_ready); end
      bus64.out_ready = 1'b1;
      #1;
      checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL x64_ready_pop[%0d]: got %b want 1", i, bus64.in_ready); end
      tick();
      checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL x64_popped[%0d]: got %b want 0", i, bus64.out_valid); end
    end
    bus64.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    int  idx = 0;
    int  popped = 0;
    logic take;
    for (int cyc = 0; cyc < 20 && popped < 4; cyc++) begin
      bus32.out_ready = (cyc >= 3);
      bus32.in_valid  = (idx < 4);
      bus32.in_instr  = (idx < 4) ? instrs[idx] : 32'h0;
      bus32.in_pc     = 32'h2000 + 32'(idx * 4);
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        checks++; if (bus32.out_valid !== 1'b1 || bus32.out_imm !== 32'h1) begin errors++; $display("[TB] FAIL b2b_hold[%0d]: got v=%b imm=%h want 1/1", cyc, bus32.out_valid, bus32.out_imm); end
      end
      if (cyc == 2 || cyc == 3) begin
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_low[%0d]: got %b want 0", cyc, bus32.in_ready); end
      end
      if (cyc >= 3) begin
        checks++;
        if (bus32.out_valid !== 1'b1 || bus32.out_imm !== 32'(popped + 1)) begin
          errors++; $display("[TB] FAIL b2b_order[%0d]: got v=%b imm=%h want 1/%h", cyc, bus32.out_valid, bus32.out_imm, 32'(popped + 1));
        end
        if (bus32.out_valid === 1'b1) popped++;
      end
      take = bus32.in_valid && bus32.in_ready;
      tick();
      if (take) idx++;
    end
    checks++; if (popped != 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d want 4", popped); end
    bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b want 0", bus32.out_valid); end
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_instr  = 32'h00100093;
    tick();
    bus32.in_instr  = 32'h00200093;
    tick();
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_two_ready: got %b want 0", bus32.in_ready); end
    flush = 1'b1;
    bus32.in_instr = 32'h00300093;
    tick();
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    checks++; if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_two: got v=%b r=%b want 0/1", bus32.out_valid, bus32.in_ready); end
    // Flush in ONE with an accept in the same cycle: that instruction must vanish too.
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h00500093;
    tick();
    flush = 1'b1;
    bus32.out_ready = 1'b1;
    bus32.in_instr = 32'h00600093;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_ungated: got %b want 1", bus32.in_ready); end
    tick();
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_emit[%0d]: got %b want 0 imm=%h", i, bus32.out_valid, bus32.out_imm); end
      tick();
    end
    bus32.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus32.out_ready = 1'b0;
    bus32.in_valid  = 1'b1;
    bus32.in_instr  = 32'h00700093;
    tick();
    bus32.in_instr  = 32'h00800093;
    tick();
    reset = 1'b1;
    bus32.in_valid = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got %b want 0", bus32.in_ready); end
    tick();
    checks++; if (bus32.out_valid !== 1'b0 || bus32.out_imm !== 32'h0 || bus32.out_immsrc !== 3'b111) begin errors++; $display("[TB] FAIL mid_reset_vals: got v=%b imm=%h src=%b want 0/0/111", bus32.out_valid, bus32.out_imm, bus32.out_immsrc); end
    reset = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_after: got %b want 1", bus32.in_ready); end
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h00900093;
    bus32.out_ready = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    checks++; if (bus32.out_valid !== 1'b1 || bus32.out_imm !== 32'h9) begin errors++; $display("[TB] FAIL mid_reset_recover: got v=%b imm=%h want 1/9", bus32.out_valid, bus32.out_imm); end
    tick();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_drain: got %b want 0", bus32.out_valid); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_decode32();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
